// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the 16-bit RISC hazard controller: FSM encoding, bubble IR, LM/SM opcodes.
// Pure definitions; no timing or flow-control behaviour of its own.
package pipeline_hazard_ctrl_pkg;

  localparam logic STATE_RUN  = 1'b0;
  localparam logic STATE_LMSM = 1'b1;

  localparam logic [15:0] NOP_IR = 16'hF000;

  localparam logic [3:0] OPC_LM = 4'b0110;
  localparam logic [3:0] OPC_SM = 4'b0111;

  function automatic logic is_lmsm_op(input logic [3:0] opc);
    return (opc == OPC_LM) || (opc == OPC_SM);
  endfunction

  function automatic logic [7:0] bit_mask8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_lowest_bit_enc.sv
// Lowest-set-bit encoder: 8-bit vector to 3-bit index plus valid.
// Purely combinational, zero latency; no flow control.
module lowest_bit_enc (
  input  logic [7:0] vec_i,
  output logic [2:0] idx_o,
  output logic       vld_o
);

  always_comb begin
    idx_o = 3'd0;
    // Scanning downward lets the lowest set bit win.
    for (int i = 7; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 3'(i);
    end
    vld_o = |vec_i;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: redirect flushes, load-use stall, LM/SM micro-op expansion.
// Mealy outputs (same cycle as inputs); state, remaining mask and stall counter update on clk.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  id_src1_i,
  input  logic [2:0]  id_src2_i,
  input  logic        id_uses_src1_i,
  input  logic        id_uses_src2_i,
  input  logic        id_is_lmsm_i,
  input  logic [7:0]  id_mask_i,
  input  logic        ex_is_load_i,
  input  logic        ex_writes_rf_i,
  input  logic [2:0]  ex_dest_i,
  input  logic        ex_branch_taken_i,
  input  logic        wb_r7_write_i,
  output logic        pc_write_o,
  output logic        if_id_hold_o,
  output logic        id_ex_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic        mem_wb_flush_o,
  output logic [2:0]  lmsm_idx_o,
  output logic        lmsm_active_o,
  output logic [15:0] stall_cycles_o
);

  logic        state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] stall_q, stall_d;

  logic [2:0]  id_idx, rem_idx;
  logic        id_vld, rem_vld;
  logic        load_use;

  lowest_bit_enc u_enc_id (
    .vec_i (id_mask_i),
    .idx_o (id_idx),
    .vld_o (id_vld)
  );

  lowest_bit_enc u_enc_rem (
    .vec_i (rem_q),
    .idx_o (rem_idx),
    .vld_o (rem_vld)
  );

  assign load_use = ex_is_load_i & ex_writes_rf_i &
                    ((id_uses_src1_i & (id_src1_i == ex_dest_i)) |
                     (id_uses_src2_i & (id_src2_i == ex_dest_i)));

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_hold_o   = 1'b0;
    id_ex_hold_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    lmsm_idx_o     = 3'd0;
    lmsm_active_o  = 1'b0;
    state_d        = state_q;
    rem_d          = rem_q;

    // The current micro-op stays visible through a load-use stall so it is re-presented next cycle.
    if (state_q == STATE_LMSM) begin
      lmsm_idx_o    = rem_idx;
      lmsm_active_o = rem_vld;
    end else if (id_is_lmsm_i && id_vld) begin
      lmsm_idx_o    = id_idx;
      lmsm_active_o = 1'b1;
    end

    if (wb_r7_write_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      mem_wb_flush_o = 1'b1;
      lmsm_idx_o     = 3'd0;
      lmsm_active_o  = 1'b0;
      state_d        = STATE_RUN;
      rem_d          = 8'd0;
    end else if (ex_branch_taken_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      lmsm_idx_o     = 3'd0;
      lmsm_active_o  = 1'b0;
      state_d        = STATE_RUN;
      rem_d          = 8'd0;
    end else if (load_use) begin
      pc_write_o     = 1'b0;
      if_id_hold_o   = 1'b1;
      id_ex_flush_o  = 1'b1;
    end else if (state_q == STATE_LMSM) begin
      rem_d = rem_q & ~bit_mask8(rem_idx);
      if (rem_d != 8'd0) begin
        pc_write_o   = 1'b0;
        if_id_hold_o = 1'b1;
      end else begin
        state_d = STATE_RUN;
      end
    end else if (id_is_lmsm_i) begin
      if (!id_vld) begin
        id_ex_flush_o = 1'b1;
      end else begin
        rem_d = id_mask_i & ~bit_mask8(id_idx);
        if (rem_d != 8'd0) begin
          pc_write_o   = 1'b0;
          if_id_hold_o = 1'b1;
          state_d      = STATE_LMSM;
        end
      end
    end
  end

  assign stall_d        = (!pc_write_o && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
  assign stall_cycles_o = stall_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= STATE_RUN;
      rem_q   <= 8'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expectations, a monitor compares.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rstn;
    logic [2:0] src1;
    logic [2:0] src2;
    logic       u1;
    logic       u2;
    logic       lmsm;
    logic [7:0] mask;
    logic       ld;
    logic       wr;
    logic [2:0] dest;
    logic       br;
    logic       r7;
  } in_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t cur;

  logic        pc_write, if_id_hold, id_ex_hold;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [2:0]  lmsm_idx;
  logic        lmsm_active;
  logic [15:0] stall_cycles;

  pipeline_hazard_ctrl dut (
    .clk_i             (clk),
    .rst_n_i           (cur.rstn),
    .id_src1_i         (cur.src1),
    .id_src2_i         (cur.src2),
    .id_uses_src1_i    (cur.u1),
    .id_uses_src2_i    (cur.u2),
    .id_is_lmsm_i      (cur.lmsm),
    .id_mask_i         (cur.mask),
    .ex_is_load_i      (cur.ld),
    .ex_writes_rf_i    (cur.wr),
    .ex_dest_i         (cur.dest),
    .ex_branch_taken_i (cur.br),
    .wb_r7_write_i     (cur.r7),
    .pc_write_o        (pc_write),
    .if_id_hold_o      (if_id_hold),
    .id_ex_hold_o      (id_ex_hold),
    .if_id_flush_o     (if_id_flush),
    .id_ex_flush_o     (id_ex_flush),
    .ex_mem_flush_o    (ex_mem_flush),
    .mem_wb_flush_o    (mem_wb_flush),
    .lmsm_idx_o        (lmsm_idx),
    .lmsm_active_o     (lmsm_active),
    .stall_cycles_o    (stall_cycles)
  );

  // Packed as {pc, if_id_hold, id_ex_hold, flush[ifid,idex,exmem,memwb], idx, active, stall}
  logic [26:0] exp_q[$];
  string       name_q[$];
  bit          chk_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] exp_stall = 16'd0;

  function automatic in_t idle();
    in_t t;
    t = '0;
    t.rstn = 1'b1;
    return t;
  endfunction

  task automatic step(input string nm, input in_t in, input logic pc, input logic ifh,
                      input logic [3:0] fl, input logic [2:0] idx, input logic act,
                      input bit chk = 1'b1);
    @(posedge clk);
    #1;
    cur = in;
    exp_q.push_back({pc, ifh, 1'b0, fl, idx, act, exp_stall});
    name_q.push_back(nm);
    chk_q.push_back(chk);
    if (!pc && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
  endtask

  initial begin
    logic [26:0] e, a;
    string       nm;
    bit          c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        c  = chk_q.pop_front();
        a  = {pc_write, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, ex_mem_flush,
              mem_wb_flush, lmsm_idx, lmsm_active, stall_cycles};
        if (c) begin
          n_cmp++;
          if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got pc=%b hold=%b%b flush=%b idx=%0d act=%b stall=%h, expected pc=%b hold=%b%b flush=%b idx=%0d act=%b stall=%h",
                     nm, a[26], a[25], a[24], a[23:20], a[19:17], a[16], a[15:0],
                     e[26], e[25], e[24], e[23:20], e[19:17], e[16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    in_t v;
    cur = '0;

    v = idle(); v.rstn = 1'b0;
    step("reset", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);
    v = idle();
    step("idle", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);

    v = idle(); v.ld = 1'b1; v.wr = 1'b1; v.dest = 3'd3; v.src2 = 3'd3; v.u2 = 1'b1;
    step("load_use", v, 1'b0, 1'b1, 4'b0100, 3'd0, 1'b0);
    v.ld = 1'b0;
    step("load_use_resume", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);
    v = idle(); v.ld = 1'b1; v.wr = 1'b1; v.dest = 3'd3; v.src1 = 3'd3; v.src2 = 3'd4; v.u2 = 1'b1;
    step("unused_src_no_stall", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);

    v = idle(); v.lmsm = 1'b1; v.mask = 8'hA5;
    step("lm_a5_idx0", v, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1);
    step("lm_a5_idx2", v, 1'b0, 1'b1, 4'b0000, 3'd2, 1'b1);
    step("lm_a5_idx5", v, 1'b0, 1'b1, 4'b0000, 3'd5, 1'b1);
    step("lm_a5_idx7", v, 1'b1, 1'b0, 4'b0000, 3'd7, 1'b1);
    v = idle();
    step("lm_a5_run", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);

    v = idle(); v.lmsm = 1'b1; v.mask = 8'h06;
    step("lm06_idx1", v, 1'b0, 1'b1, 4'b0000, 3'd1, 1'b1);
    v.ld = 1'b1; v.wr = 1'b1; v.dest = 3'd2; v.src1 = 3'd2; v.u1 = 1'b1;
    step("lm06_load_use", v, 1'b0, 1'b1, 4'b0100, 3'd2, 1'b1);
    v.ld = 1'b0;
    step("lm06_idx2_again", v, 1'b1, 1'b0, 4'b0000, 3'd2, 1'b1);
    v = idle();
    step("lm06_run", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);

    v = idle(); v.lmsm = 1'b1; v.mask = 8'hFF;
    step("ff_idx0", v, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1);
    v.br = 1'b1;
    step("ff_branch_abort", v, 1'b1, 1'b0, 4'b1100, 3'd0, 1'b0);
    v = idle();
    step("ff_after_abort", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);

    v = idle(); v.lmsm = 1'b1; v.mask = 8'hFF; v.r7 = 1'b1; v.br = 1'b1;
    v.ld = 1'b1; v.wr = 1'b1; v.dest = 3'd1; v.src1 = 3'd1; v.u1 = 1'b1;
    step("all_redirect", v, 1'b1, 1'b0, 4'b1111, 3'd0, 1'b0);
    v = idle();
    step("all_after", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);

    v = idle(); v.lmsm = 1'b1; v.mask = 8'h00;
    step("lm_mask0_bubble", v, 1'b1, 1'b0, 4'b0100, 3'd0, 1'b0);
    v = idle();
    step("lm_mask0_after", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);

    v = idle(); v.lmsm = 1'b1; v.mask = 8'hFF;
    step("rst_seq_idx0", v, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1);
    step("rst_seq_idx1", v, 1'b0, 1'b1, 4'b0000, 3'd1, 1'b1);
    v = idle(); v.rstn = 1'b0;
    exp_stall = 16'd0;
    step("reset_mid_lmsm", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);
    v = idle();
    step("post_reset_run", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);

    v = idle(); v.ld = 1'b1; v.wr = 1'b1; v.dest = 3'd5; v.src1 = 3'd5; v.u1 = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      step("saturate", v, 1'b0, 1'b1, 4'b0100, 3'd0, 1'b0, (i % 10000 == 0) || (i >= 69990));
    end
    v = idle();
    step("stall_saturated", v, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
